// File: rtl/regbus_pkg.sv
// Shared types for the register-bus arbiter: completion codes, FSM encoding, default timeout.
// Pure declarations; no timing or flow-control behaviour of its own.
package regbus_pkg;

  localparam int def_timeout_cyc = 255;

  typedef enum logic [1:0] {
    st_ok      = 2'b00,
    st_nack    = 2'b01,
    st_unknown = 2'b10,
    st_timeout = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    s_idle  = 2'b00,
    s_issue = 2'b01,
    s_wait  = 2'b10,
    s_done  = 2'b11
  } state_t;

  // Simultaneous responses resolve with ack strongest, unknown weakest.
  function automatic status_t resolve_resp(input logic ack, input logic nack, input logic unknown);
    if (ack) return st_ok;
    if (nack) return st_nack;
    if (unknown) return st_unknown;
    return st_unknown;
  endfunction

endpackage

// File: rtl/regbus_timer.sv
// Response watchdog: counts enabled cycles since clear, saturating at LIMIT.
// expired is combinational on the count; no flow control.
module regbus_timer
  import regbus_pkg::*;
#(
  parameter int LIMIT = def_timeout_cyc
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt >= CW'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/regbus_arb.sv
// Round-robin arbiter of two level-held requesters onto one register bus, one transaction at a time.
// Strobe one cycle after grant, done one cycle after the first response; losers simply stay held.
module regbus_arb
  import regbus_pkg::*;
#(
  parameter int TIMEOUT_CYC = def_timeout_cyc,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          rq_wr,
  input  logic [1:0]          rq_rd,
  input  logic [2*ADDR_W-1:0] rq_addr,
  input  logic [2*DATA_W-1:0] rq_data,
  output logic [1:0]          rq_done,
  output logic [1:0]          rq_status,
  output logic [DATA_W-1:0]   rq_rdata,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data,
  output logic                wr,
  output logic                rd,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ack,
  input  logic                nack,
  input  logic                unknown,
  output logic                timeout
);

  state_t  state, state_nxt;
  status_t status;

  logic [1:0] req;
  logic       gnt_sel;
  logic       gnt;
  logic       last_gnt;
  logic       lat_rd;
  logic       sel_both;
  logic       any_resp;
  logic       expired;
  logic       tmr_clr;
  logic       tmr_en;

  assign req      = rq_wr | rq_rd;
  assign any_resp = ack | nack | unknown;
  // With both requesting, the one not granted last wins.
  assign gnt_sel  = (req == 2'b11) ? ~last_gnt : req[1];
  assign sel_both = rq_wr[gnt_sel] & rq_rd[gnt_sel];

  assign rq_status = status;

  regbus_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= s_idle;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      s_idle:  if (|req) state_nxt = sel_both ? s_done : s_issue;
      s_issue: state_nxt = any_resp ? s_done : s_wait;
      s_wait:  if (any_resp || expired) state_nxt = s_done;
      s_done:  state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase
  end

  always_comb begin
    wr      = 1'b0;
    rd      = 1'b0;
    rq_done = 2'b00;
    timeout = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state)
      s_idle:  tmr_clr = 1'b1;
      s_issue: begin
        wr     = ~lat_rd;
        rd     = lat_rd;
        tmr_en = 1'b1;
      end
      s_wait:  tmr_en = 1'b1;
      s_done:  begin
        rq_done[gnt] = 1'b1;
        timeout      = (status == st_timeout);
        tmr_clr      = 1'b1;
      end
      default: tmr_clr = 1'b1;
    endcase
  end

  // Grant latches plus completion status; a response beats an expiring timer in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      lat_rd   <= 1'b0;
      addr     <= '0;
      data     <= '0;
      rq_rdata <= '0;
      status   <= st_ok;
    end else begin
      if (state == s_idle && |req) begin
        gnt      <= gnt_sel;
        last_gnt <= gnt_sel;
        lat_rd   <= rq_rd[gnt_sel];
        addr     <= gnt_sel ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
        data     <= gnt_sel ? rq_data[2*DATA_W-1:DATA_W] : rq_data[DATA_W-1:0];
        if (sel_both) status <= st_unknown;
      end
      if ((state == s_issue || state == s_wait) && any_resp) begin
        status <= resolve_resp(ack, nack, unknown);
        if (ack && lat_rd) rq_rdata <= rdata;
      end else if (state == s_wait && expired) begin
        status <= st_timeout;
      end
    end
  end

endmodule

// File: tb/tb_regbus_arb.sv
// Bench for regbus_arb: directed scenarios with literal expectations, then random traffic,
// all cycles compared against a transaction-level model keyed on absolute cycle numbers.
module tb_regbus_arb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rq_wr = 2'b00;
  logic [1:0]  rq_rd = 2'b00;
  logic [31:0] rq_addr = '0;
  logic [63:0] rq_data = '0;
  logic [1:0]  rq_done;
  logic [1:0]  rq_status;
  logic [31:0] rq_rdata;
  logic [15:0] addr;
  logic [31:0] data;
  logic        wr, rd, timeout;
  logic [31:0] rdata = '0;
  logic        ack = 1'b0, nack = 1'b0, unknown = 1'b0;

  regbus_arb #(.TIMEOUT_CYC(TMO), .ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rq_wr(rq_wr), .rq_rd(rq_rd), .rq_addr(rq_addr), .rq_data(rq_data),
    .rq_done(rq_done), .rq_status(rq_status), .rq_rdata(rq_rdata), .addr(addr), .data(data),
    .wr(wr), .rd(rd), .rdata(rdata), .ack(ack), .nack(nack), .unknown(unknown), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: expected outputs for the current cycle.
  int          m_cyc = 0, m_free = 0, m_s = 0, m_done_cyc = -1, m_g = 0, m_last = 1;
  bit          m_pend = 1'b0, m_rd = 1'b0;
  logic [1:0]  m_stat = 2'b00;
  logic [15:0] e_addr = '0;
  logic [31:0] e_data = '0, e_rdata = '0;
  logic [1:0]  e_done = 2'b00, e_stat = 2'b00;
  logic        e_wr = 1'b0, e_rd = 1'b0, e_to = 1'b0;

  initial begin : model
    int c;
    logic [1:0] rq;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend = 0; m_free = 0; m_last = 1; m_done_cyc = -1; m_stat = 0;
        e_addr = '0; e_data = '0; e_rdata = '0; e_stat = 0;
        e_wr = 0; e_rd = 0; e_done = 0; e_to = 0;
      end else begin
        c  = m_cyc;
        rq = rq_wr | rq_rd;
        if (m_pend) begin
          if (ack || nack || unknown) begin
            m_stat = ack ? 2'd0 : (nack ? 2'd1 : 2'd2);
            if (ack && m_rd) e_rdata = rdata;
            m_done_cyc = c + 1;
            m_pend = 0;
          end else if (c - m_s == TMO) begin
            m_stat = 2'd3;
            m_done_cyc = c + 1;
            m_pend = 0;
          end
        end else if (c >= m_free && rq != 2'b00) begin
          m_g = (rq == 2'b11) ? 1 - m_last : (rq[1] ? 1 : 0);
          m_last = m_g;
          e_addr = rq_addr[m_g*16 +: 16];
          e_data = rq_data[m_g*32 +: 32];
          if (rq_wr[m_g] && rq_rd[m_g]) begin
            m_stat = 2'd2;
            m_done_cyc = c + 1;
          end else begin
            m_rd = rq_rd[m_g];
            m_s = c + 1;
            m_pend = 1;
          end
        end
        if (!m_pend && m_done_cyc == c + 1) m_free = c + 2;
        m_cyc  = c + 1;
        e_wr   = m_pend && (m_cyc == m_s) && !m_rd;
        e_rd   = m_pend && (m_cyc == m_s) && m_rd;
        e_done = (m_cyc == m_done_cyc) ? ((m_g == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_to   = (m_cyc == m_done_cyc) && (m_stat == 2'd3);
        e_stat = m_stat;
      end
    end
  end

  int          n_chk = 0, n_err = 0, strobes = 0;
  int          resp_cnt = -1, cfg_delay = 0;
  bit          cfg_none = 1'b1, rand_mode = 1'b0, chk_en = 1'b0;
  logic [2:0]  cfg_kind = 3'b001;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  drop_pend = 2'b00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic launch(input int i, input bit w, input bit r, input logic [15:0] a, input logic [31:0] d);
    rq_wr[i] = w;
    rq_rd[i] = r;
    rq_addr[i*16 +: 16] = a;
    rq_data[i*32 +: 32] = d;
  endtask

  task automatic model_compare();
    chk("wr", {63'b0, wr}, {63'b0, e_wr});
    chk("rd", {63'b0, rd}, {63'b0, e_rd});
    chk("rq_done", {62'b0, rq_done}, {62'b0, e_done});
    chk("timeout", {63'b0, timeout}, {63'b0, e_to});
    chk("addr", {48'b0, addr}, {48'b0, e_addr});
    chk("data", {32'b0, data}, {32'b0, e_data});
    chk("rq_rdata", {32'b0, rq_rdata}, {32'b0, e_rdata});
    if (e_done != 2'b00) chk("rq_status", {62'b0, rq_status}, {62'b0, e_stat});
  endtask

  // One clock: requester drops/launches and the bus responder act just after the edge,
  // outputs are compared at the falling edge.
  task automatic step();
    bit [1:0] dropped;
    int k;
    dropped = 2'b00;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (drop_pend[i]) begin
        rq_wr[i] = 1'b0;
        rq_rd[i] = 1'b0;
        drop_pend[i] = 1'b0;
        dropped[i] = 1'b1;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (!dropped[i] && !rq_wr[i] && !rq_rd[i] && $urandom_range(3) == 0) begin
          k = $urandom_range(15);
          launch(i, k < 8, (k == 0) || (k >= 8), 16'($urandom), $urandom);
        end
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(399) == 0) rst = 1'b1;
    end
    ack = 1'b0; nack = 1'b0; unknown = 1'b0;
    rdata = $urandom;
    if (rst) begin
      resp_cnt = -1;
    end else if (wr || rd) begin
      if (rand_mode) begin
        cfg_delay = $urandom_range(TMO + 1);
        cfg_kind  = 3'($urandom_range(7, 1));
        cfg_none  = ($urandom_range(7) == 0);
        cfg_rdata = $urandom;
      end
      resp_cnt = cfg_none ? -1 : cfg_delay;
    end
    if (resp_cnt == 0) begin
      {unknown, nack, ack} = cfg_kind;
      rdata = cfg_rdata;
      resp_cnt = -1;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
    end
    @(negedge clk);
    if (wr || rd) strobes++;
    if (chk_en) model_compare();
    drop_pend = drop_pend | rq_done;
  endtask

  task automatic run_until_done(input int max, output int n, output logic [1:0] d,
                                output logic [1:0] st, output logic to);
    n = 0; d = 2'b00; st = 2'b00; to = 1'b0;
    while (d == 2'b00 && n < max) begin
      step();
      n++;
      d = rq_done; st = rq_status; to = timeout;
    end
    chk("done_seen", {63'b0, (d != 2'b00)}, 64'd1);
  endtask

  initial begin : main
    int n;
    logic [1:0] d, st;
    logic to;
    logic [2:0] kinds [3];
    logic [1:0] stats [3];
    kinds = '{3'b011, 3'b010, 3'b100};
    stats = '{2'd0, 2'd1, 2'd2};

    step(); step();
    chk_en = 1'b1;
    step();
    chk("rst_wr", {63'b0, wr}, 64'd0);
    chk("rst_rd", {63'b0, rd}, 64'd0);
    chk("rst_done", {62'b0, rq_done}, 64'd0);
    chk("rst_timeout", {63'b0, timeout}, 64'd0);
    chk("rst_addr", {48'b0, addr}, 64'd0);
    chk("rst_rdata", {32'b0, rq_rdata}, 64'd0);
    chk("rst_status", {62'b0, rq_status}, 64'd0);
    rst = 1'b0;
    step();

    // Write with ack one cycle after the strobe.
    cfg_none = 0; cfg_delay = 1; cfg_kind = 3'b001;
    strobes = 0;
    launch(0, 1, 0, 16'h9004, 32'hDEADBEEF);
    step();
    chk("t1_wr", {63'b0, wr}, 64'd1);
    chk("t1_addr", {48'b0, addr}, 64'h9004);
    chk("t1_data", {32'b0, data}, 64'hDEADBEEF);
    step();
    chk("t1_wr_off", {63'b0, wr}, 64'd0);
    chk("t1_done_early", {62'b0, rq_done}, 64'd0);
    step();
    chk("t1_done", {62'b0, rq_done}, 64'd1);
    chk("t1_status", {62'b0, rq_status}, 64'd0);
    chk("t1_pulses", 64'(strobes), 64'd1);
    step();

    // Round robin from reset: 0 then 1; after a lone 0, a tie goes to 1.
    rst = 1'b1; step(); rst = 1'b0; step();
    cfg_delay = 0;
    launch(0, 1, 0, 16'h1000, 32'h1);
    launch(1, 1, 0, 16'h1100, 32'h2);
    run_until_done(20, n, d, st, to); chk("t2_first", {62'b0, d}, 64'b01);
    run_until_done(20, n, d, st, to); chk("t2_second", {62'b0, d}, 64'b10);
    step();
    launch(0, 0, 1, 16'h1200, 32'h0);
    run_until_done(20, n, d, st, to); chk("t2_lone", {62'b0, d}, 64'b01);
    step();
    launch(0, 1, 0, 16'h1300, 32'h3);
    launch(1, 1, 0, 16'h1400, 32'h4);
    run_until_done(20, n, d, st, to); chk("t2_rep_first", {62'b0, d}, 64'b10);
    run_until_done(20, n, d, st, to); chk("t2_rep_second", {62'b0, d}, 64'b01);
    step();

    // Read data capture.
    cfg_delay = 0; cfg_kind = 3'b001; cfg_rdata = 32'h12345678;
    launch(1, 0, 1, 16'h9010, 32'h0);
    run_until_done(20, n, d, st, to);
    chk("t3_done", {62'b0, d}, 64'b10);
    chk("t3_status", {62'b0, st}, 64'd0);
    chk("t3_rdata", {32'b0, rq_rdata}, 64'h12345678);
    step();

    // Timeout, then an ack landing exactly at the limit.
    cfg_none = 1;
    launch(0, 1, 0, 16'h2000, 32'h5);
    step();
    chk("t4_strobe", {63'b0, wr}, 64'd1);
    run_until_done(30, n, d, st, to);
    chk("t4_latency", 64'(n), 64'(TMO + 1));
    chk("t4_timeout", {63'b0, to}, 64'd1);
    chk("t4_status", {62'b0, st}, 64'd3);
    step();
    cfg_none = 0; cfg_delay = TMO; cfg_kind = 3'b001;
    launch(0, 1, 0, 16'h2004, 32'h6);
    step();
    run_until_done(30, n, d, st, to);
    chk("t4b_latency", 64'(n), 64'(TMO + 1));
    chk("t4b_timeout", {63'b0, to}, 64'd0);
    chk("t4b_status", {62'b0, st}, 64'd0);
    step();

    // Response priority and the wr+rd illegal combination.
    for (int i = 0; i < 3; i++) begin
      cfg_kind = kinds[i];
      cfg_delay = $urandom_range(3);
      launch(0, 1, 0, 16'(16'h2100 + i), 32'(i));
      run_until_done(20, n, d, st, to);
      chk("t5_status", {62'b0, st}, {62'b0, stats[i]});
      step();
    end
    strobes = 0;
    launch(1, 1, 1, 16'h2200, 32'h7);
    run_until_done(20, n, d, st, to);
    chk("t5_both_lat", 64'(n), 64'd1);
    chk("t5_both_done", {62'b0, d}, 64'b10);
    chk("t5_both_status", {62'b0, st}, 64'd2);
    chk("t5_both_nostrobe", 64'(strobes), 64'd0);
    step();

    // Reset mid-WAIT, then the still-held request is served from scratch.
    cfg_none = 1;
    launch(0, 1, 0, 16'h3000, 32'hCAFE);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("t6_wr", {63'b0, wr}, 64'd0);
    chk("t6_done", {62'b0, rq_done}, 64'd0);
    chk("t6_timeout", {63'b0, timeout}, 64'd0);
    chk("t6_addr", {48'b0, addr}, 64'd0);
    chk("t6_data", {32'b0, data}, 64'd0);
    chk("t6_rdata", {32'b0, rq_rdata}, 64'd0);
    chk("t6_status", {62'b0, rq_status}, 64'd0);
    rst = 1'b0;
    cfg_none = 0; cfg_delay = 0; cfg_kind = 3'b001;
    run_until_done(20, n, d, st, to);
    chk("t6_after_done", {62'b0, d}, 64'b01);
    chk("t6_after_status", {62'b0, st}, 64'd0);
    chk("t6_after_addr", {48'b0, addr}, 64'h3000);
    step();

    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    rand_mode = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
